// File: rtl/block_mover_pkg.sv
// block_mover_pkg
// Shared definitions for the block mover: default width parameters, the handle
// word width and layout, and the mover FSM state encoding.
//   LANE_FIFO_ADDR_W    lane FIFO address width (depth 32)
//   HANDLE_ADDR_W       handle FIFO address width (depth 1024)
//   PAGE_ADDR_W         page RAM address width
//   MAX_PKT_LENGTH_BITS handle length field width (length counts words)
//   DATA_W              lane / page word width
//   HANDLE_W            handle word width
package block_mover_pkg;

    localparam int LANE_FIFO_ADDR_W    = 5;
    localparam int HANDLE_ADDR_W       = 10;
    localparam int PAGE_ADDR_W         = 18;
    localparam int MAX_PKT_LENGTH_BITS = 8;
    localparam int DATA_W              = 40;
    localparam int HANDLE_W            = LANE_FIFO_ADDR_W + PAGE_ADDR_W + MAX_PKT_LENGTH_BITS + 1;

    // Handle word at the default widths, MSB first.
    typedef struct packed {
        logic                           drop;
        logic [MAX_PKT_LENGTH_BITS-1:0] len;
        logic [PAGE_ADDR_W-1:0]         page_addr;
        logic [LANE_FIFO_ADDR_W-1:0]    src_addr;
    } handle_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MOVE   = 3'd3,
        ST_DONE   = 3'd4
    } bm_state_e;

endpackage

// File: rtl/bm_out_buf.sv
// bm_out_buf
// Two-entry skid buffer between the lane read pipeline and the page-write
// arbiter. The head entry drives req/addr/data and only changes when it is
// granted or when the buffer is empty, so the request stays stable until gnt.
// Ports:
//   clk, rst              clock, synchronous active-high reset (empties buffer)
//   push, push_addr/data  word arriving from the lane RAM
//   gnt                   arbiter grant; a transfer is req & gnt
//   req, addr, data       page write request presented to the arbiter
//   count                 entries held (0..2)
module bm_out_buf #(
    parameter int ADDR_W = 18,
    parameter int WORD_W = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [WORD_W-1:0] push_data,
    input  logic              gnt,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] data,
    output logic [1:0]        count
);

    import block_mover_pkg::*;

    logic              head_vld_r;
    logic              skid_vld_r;
    logic [ADDR_W-1:0] head_addr_r;
    logic [WORD_W-1:0] head_data_r;
    logic [ADDR_W-1:0] skid_addr_r;
    logic [WORD_W-1:0] skid_data_r;
    logic              pop_s;

    assign pop_s = head_vld_r & gnt;

    // Head/skid storage; the skid entry is only ever valid behind a valid head.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_vld_r  <= 1'b0;
            skid_vld_r  <= 1'b0;
            head_addr_r <= {ADDR_W{1'b0}};
            head_data_r <= {WORD_W{1'b0}};
            skid_addr_r <= {ADDR_W{1'b0}};
            skid_data_r <= {WORD_W{1'b0}};
        end else if (pop_s) begin
            if (skid_vld_r) begin
                head_addr_r <= skid_addr_r;
                head_data_r <= skid_data_r;
                skid_vld_r  <= push;
                if (push) begin
                    skid_addr_r <= push_addr;
                    skid_data_r <= push_data;
                end
            end else begin
                head_vld_r <= push;
                if (push) begin
                    head_addr_r <= push_addr;
                    head_data_r <= push_data;
                end
            end
        end else begin
            if (!head_vld_r) begin
                head_vld_r <= push;
                if (push) begin
                    head_addr_r <= push_addr;
                    head_data_r <= push_data;
                end
            end else if (push) begin
                skid_vld_r  <= 1'b1;
                skid_addr_r <= push_addr;
                skid_data_r <= push_data;
            end
        end
    end

    assign req   = head_vld_r;
    assign addr  = head_addr_r;
    assign data  = head_data_r;
    assign count = {skid_vld_r, head_vld_r & ~skid_vld_r};

endmodule

// File: rtl/block_mover.sv
// block_mover
// Pops handles from a handle FIFO, reads len words from the lane FIFO starting
// at src_addr and writes them to consecutive page RAM addresses through an
// arbitrated page-write port, then frees the lane words and retires the handle.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   handle_wptr / handle_rptr       handle FIFO pointers (in / out)
//   handle_rd_addr, handle_rd_data  handle RAM read port (1-cycle latency)
//   lane_wptr / lane_rptr           lane FIFO pointers (in / out)
//   lane_rd_en/addr, lane_rd_data   lane RAM read port (data next cycle)
//   page_wr_req/gnt/waddr/wdata     page-write arbiter handshake
//   mover_busy                      high while a handle is in flight
// Optional build macro BLOCK_MOVER_STATS_EN adds saturating counters
//   stat_words (granted page writes) and stat_drops (dropped handles).
module block_mover #(
    parameter int LANE_FIFO_ADDR_W    = block_mover_pkg::LANE_FIFO_ADDR_W,
    parameter int HANDLE_ADDR_W       = block_mover_pkg::HANDLE_ADDR_W,
    parameter int PAGE_ADDR_W         = block_mover_pkg::PAGE_ADDR_W,
    parameter int MAX_PKT_LENGTH_BITS = block_mover_pkg::MAX_PKT_LENGTH_BITS,
    parameter int DATA_W              = block_mover_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [HANDLE_ADDR_W-1:0]    handle_wptr,
    output logic [HANDLE_ADDR_W-1:0]    handle_rd_addr,
    input  logic [LANE_FIFO_ADDR_W+PAGE_ADDR_W+MAX_PKT_LENGTH_BITS:0] handle_rd_data,
    output logic [HANDLE_ADDR_W-1:0]    handle_rptr,
    input  logic [LANE_FIFO_ADDR_W-1:0] lane_wptr,
    output logic                        lane_rd_en,
    output logic [LANE_FIFO_ADDR_W-1:0] lane_rd_addr,
    input  logic [DATA_W-1:0]           lane_rd_data,
    output logic [LANE_FIFO_ADDR_W-1:0] lane_rptr,
    output logic                        page_wr_req,
    input  logic                        page_wr_gnt,
    output logic [PAGE_ADDR_W-1:0]      page_waddr,
    output logic [DATA_W-1:0]           page_wdata,
    output logic                        mover_busy
`ifdef BLOCK_MOVER_STATS_EN
    ,
    output logic [31:0]                 stat_words,
    output logic [15:0]                 stat_drops
`endif
);

    import block_mover_pkg::*;

    // Handle field positions, LSB first.
    localparam int PAGE_LSB = LANE_FIFO_ADDR_W;
    localparam int LEN_LSB  = PAGE_LSB + PAGE_ADDR_W;
    localparam int DROP_BIT = LEN_LSB + MAX_PKT_LENGTH_BITS;

    localparam logic [LANE_FIFO_ADDR_W-1:0]    LANE_ONE = {{(LANE_FIFO_ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [HANDLE_ADDR_W-1:0]       HPTR_ONE = {{(HANDLE_ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [PAGE_ADDR_W-1:0]         PAGE_ONE = {{(PAGE_ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [MAX_PKT_LENGTH_BITS-1:0] CNT_ONE  = {{(MAX_PKT_LENGTH_BITS-1){1'b0}}, 1'b1};
    localparam logic [MAX_PKT_LENGTH_BITS-1:0] CNT_ZERO = {MAX_PKT_LENGTH_BITS{1'b0}};

    bm_state_e                      state_r;
    bm_state_e                      state_nxt_s;

    logic [HANDLE_ADDR_W-1:0]       handle_rptr_r;
    logic [LANE_FIFO_ADDR_W-1:0]    lane_rptr_r;
    logic [LANE_FIFO_ADDR_W-1:0]    lane_rd_addr_r;
    logic [LANE_FIFO_ADDR_W-1:0]    src_r;
    logic [MAX_PKT_LENGTH_BITS-1:0] len_r;
    logic [MAX_PKT_LENGTH_BITS-1:0] rd_cnt_r;
    logic [MAX_PKT_LENGTH_BITS-1:0] wr_cnt_r;
    logic [PAGE_ADDR_W-1:0]         page_ptr_r;
    logic                           rd_vld_r;

    logic                           dec_drop_s;
    logic [MAX_PKT_LENGTH_BITS-1:0] dec_len_s;
    logic [PAGE_ADDR_W-1:0]         dec_page_s;
    logic [LANE_FIFO_ADDR_W-1:0]    dec_src_s;

    logic                           grant_s;
    logic                           lane_rd_en_s;
    logic                           mover_busy_s;
    logic [1:0]                     buf_count_s;
    logic [2:0]                     buf_load_s;
    logic [LANE_FIFO_ADDR_W+MAX_PKT_LENGTH_BITS-1:0] lane_end_wide_s;

    assign dec_drop_s = handle_rd_data[DROP_BIT];
    assign dec_len_s  = handle_rd_data[DROP_BIT-1:LEN_LSB];
    assign dec_page_s = handle_rd_data[LEN_LSB-1:PAGE_LSB];
    assign dec_src_s  = handle_rd_data[PAGE_LSB-1:0];

    assign grant_s = page_wr_req & page_wr_gnt;

    // src+len computed wide so any len width wraps correctly on the lane ring.
    assign lane_end_wide_s = {{MAX_PKT_LENGTH_BITS{1'b0}}, src_r}
                           + {{LANE_FIFO_ADDR_W{1'b0}}, len_r};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (handle_rptr_r != handle_wptr) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_nxt_s = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_drop_s || (dec_len_s == CNT_ZERO)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (grant_s && ((wr_cnt_r + CNT_ONE) == len_r)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MOVE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs. A read is issued only if, after this cycle's pop, at most one
    // entry is held or in flight, so the returning word always finds a slot.
    // rst gates the read strobe so an abort takes effect in the same cycle.
    always_comb begin
        mover_busy_s = 1'b0;
        lane_rd_en_s = 1'b0;
        buf_load_s   = {1'b0, buf_count_s} + {2'b00, rd_vld_r} - {2'b00, grant_s};
        if (state_r != ST_IDLE) begin
            mover_busy_s = 1'b1;
        end else begin
            mover_busy_s = 1'b0;
        end
        if ((state_r == ST_MOVE) && !rst && (rd_cnt_r != len_r) &&
            (lane_rd_addr_r != lane_wptr) && (buf_load_s <= 3'd1)) begin
            lane_rd_en_s = 1'b1;
        end else begin
            lane_rd_en_s = 1'b0;
        end
    end

    // Handle latch, lane read pointer, word counters and FIFO pointer updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            handle_rptr_r  <= {HANDLE_ADDR_W{1'b0}};
            lane_rptr_r    <= {LANE_FIFO_ADDR_W{1'b0}};
            lane_rd_addr_r <= {LANE_FIFO_ADDR_W{1'b0}};
            src_r          <= {LANE_FIFO_ADDR_W{1'b0}};
            len_r          <= CNT_ZERO;
            rd_cnt_r       <= CNT_ZERO;
            wr_cnt_r       <= CNT_ZERO;
            page_ptr_r     <= {PAGE_ADDR_W{1'b0}};
            rd_vld_r       <= 1'b0;
        end else begin
            rd_vld_r <= lane_rd_en_s;
            case (state_r)
                ST_DECODE: begin
                    src_r          <= dec_src_s;
                    len_r          <= dec_len_s;
                    page_ptr_r     <= dec_page_s;
                    lane_rd_addr_r <= dec_src_s;
                    rd_cnt_r       <= CNT_ZERO;
                    wr_cnt_r       <= CNT_ZERO;
                end
                ST_MOVE: begin
                    if (lane_rd_en_s) begin
                        lane_rd_addr_r <= lane_rd_addr_r + LANE_ONE;
                        rd_cnt_r       <= rd_cnt_r + CNT_ONE;
                    end
                    // The page address travels with each word as it enters the buffer.
                    if (rd_vld_r) begin
                        page_ptr_r <= page_ptr_r + PAGE_ONE;
                    end
                    if (grant_s) begin
                        wr_cnt_r <= wr_cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    lane_rptr_r   <= lane_end_wide_s[LANE_FIFO_ADDR_W-1:0];
                    handle_rptr_r <= handle_rptr_r + HPTR_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    bm_out_buf #(
        .ADDR_W (PAGE_ADDR_W),
        .WORD_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_vld_r),
        .push_addr (page_ptr_r),
        .push_data (lane_rd_data),
        .gnt       (page_wr_gnt),
        .req       (page_wr_req),
        .addr      (page_waddr),
        .data      (page_wdata),
        .count     (buf_count_s)
    );

    assign handle_rd_addr = handle_rptr_r;
    assign handle_rptr    = handle_rptr_r;
    assign lane_rptr      = lane_rptr_r;
    assign lane_rd_addr   = lane_rd_addr_r;
    assign lane_rd_en     = lane_rd_en_s;
    assign mover_busy     = mover_busy_s;

`ifdef BLOCK_MOVER_STATS_EN
    logic [31:0] stat_words_r;
    logic [15:0] stat_drops_r;

    // Saturating counters of granted page writes and dropped handles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words_r <= 32'd0;
            stat_drops_r <= 16'd0;
        end else begin
            if (grant_s && (stat_words_r != 32'hFFFF_FFFF)) begin
                stat_words_r <= stat_words_r + 32'd1;
            end
            if ((state_r == ST_DECODE) && dec_drop_s && (stat_drops_r != 16'hFFFF)) begin
                stat_drops_r <= stat_drops_r + 16'd1;
            end
        end
    end

    assign stat_words = stat_words_r;
    assign stat_drops = stat_drops_r;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_block_mover.sv
// tb_block_mover
// Self-checking bench for block_mover: behavioural handle/lane RAMs, a table of
// directed handles, a reset-during-move sequence and randomized handles, all
// checked against a queue-based reference of the expected page writes.
module tb_block_mover;

    import block_mover_pkg::*;

    localparam int G_ONE    = 0;
    localparam int G_TOGGLE = 1;
    localparam int G_RAND   = 2;
    localparam int L_FULL    = 0;
    localparam int L_TRICKLE = 1;
    localparam int BUDGET    = 800;

    typedef struct {
        logic        drop;
        logic [7:0]  len;
        logic [17:0] page;
        logic [4:0]  src;
        int          gmode;
        int          lmode;
        logic [4:0]  exp_lane_rptr;
        int          exp_writes;
        bit          exp_consec;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [17:0] addr;
        logic [39:0] data;
    } wr_t;

    logic                        clk;
    logic                        rst;
    logic [HANDLE_ADDR_W-1:0]    handle_wptr;
    logic [HANDLE_ADDR_W-1:0]    handle_rd_addr;
    logic [HANDLE_W-1:0]         handle_rd_data;
    logic [HANDLE_ADDR_W-1:0]    handle_rptr;
    logic [LANE_FIFO_ADDR_W-1:0] lane_wptr;
    logic                        lane_rd_en;
    logic [LANE_FIFO_ADDR_W-1:0] lane_rd_addr;
    logic [DATA_W-1:0]           lane_rd_data;
    logic [LANE_FIFO_ADDR_W-1:0] lane_rptr;
    logic                        page_wr_req;
    logic                        page_wr_gnt;
    logic [PAGE_ADDR_W-1:0]      page_waddr;
    logic [DATA_W-1:0]           page_wdata;
    logic                        mover_busy;
`ifdef BLOCK_MOVER_STATS_EN
    logic [31:0]                 stat_words;
    logic [15:0]                 stat_drops;
`endif

    logic [HANDLE_W-1:0] handle_mem [0:(1<<HANDLE_ADDR_W)-1];
    logic [DATA_W-1:0]   lane_mem   [0:(1<<LANE_FIFO_ADDR_W)-1];

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   gmode = G_ONE;
    int   lmode = L_FULL;
    int   trickle_cnt = 0;
    logic [4:0] lane_end = 5'd0;
    logic [9:0] hptr_model = 10'd0;
    wr_t        got_q[$];
    logic [4:0] rd_q[$];
    logic        stall_prev = 1'b0;
    logic [17:0] prev_addr = 18'd0;
    logic [39:0] prev_data = 40'd0;
    vec_t        vecs [8];

    block_mover dut (
        .clk            (clk),
        .rst            (rst),
        .handle_wptr    (handle_wptr),
        .handle_rd_addr (handle_rd_addr),
        .handle_rd_data (handle_rd_data),
        .handle_rptr    (handle_rptr),
        .lane_wptr      (lane_wptr),
        .lane_rd_en     (lane_rd_en),
        .lane_rd_addr   (lane_rd_addr),
        .lane_rd_data   (lane_rd_data),
        .lane_rptr      (lane_rptr),
        .page_wr_req    (page_wr_req),
        .page_wr_gnt    (page_wr_gnt),
        .page_waddr     (page_waddr),
        .page_wdata     (page_wdata),
        .mover_busy     (mover_busy)
`ifdef BLOCK_MOVER_STATS_EN
        ,
        .stat_words     (stat_words),
        .stat_drops     (stat_drops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAMs with one cycle of read latency.
    always @(posedge clk) begin
        handle_rd_data <= handle_mem[handle_rd_addr];
        if (lane_rd_en) lane_rd_data <= lane_mem[lane_rd_addr];
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: records lane reads and page transfers, checks read bound and request hold.
    always @(negedge clk) begin
        if (lane_rd_en) begin
            rd_q.push_back(lane_rd_addr);
            chk("lane_read_past_wptr", 64'(lane_rd_addr == lane_wptr), 64'd0);
        end
        if (page_wr_req && page_wr_gnt) begin
            got_q.push_back('{cyc, page_waddr, page_wdata});
        end
        if (stall_prev && !rst) begin
            chk("req_hold", {5'd0, page_wr_req, page_waddr, page_wdata}, {5'd0, 1'b1, prev_addr, prev_data});
        end
        stall_prev = page_wr_req && !page_wr_gnt && !rst;
        prev_addr  = page_waddr;
        prev_data  = page_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (gmode)
            G_ONE:    page_wr_gnt = 1'b1;
            G_TOGGLE: page_wr_gnt = ~page_wr_gnt;
            default:  page_wr_gnt = 1'($urandom_range(0, 1));
        endcase
        if (lmode == L_TRICKLE) begin
            trickle_cnt++;
            if (trickle_cnt == 3) begin
                trickle_cnt = 0;
                if (lane_wptr != lane_end) lane_wptr = lane_wptr + 5'd1;
            end
        end
        @(negedge clk);
        #1;
    endtask

    function automatic void chk_all_zero(string tag);
        chk({tag, "_handle_rptr"},    64'(handle_rptr), 64'd0);
        chk({tag, "_lane_rptr"},      64'(lane_rptr), 64'd0);
        chk({tag, "_handle_rd_addr"}, 64'(handle_rd_addr), 64'd0);
        chk({tag, "_lane_rd_addr"},   64'(lane_rd_addr), 64'd0);
        chk({tag, "_lane_rd_en"},     64'(lane_rd_en), 64'd0);
        chk({tag, "_page_wr_req"},    64'(page_wr_req), 64'd0);
        chk({tag, "_mover_busy"},     64'(mover_busy), 64'd0);
        chk({tag, "_page_waddr"},     64'(page_waddr), 64'd0);
        chk({tag, "_page_wdata"},     64'(page_wdata), 64'd0);
    endfunction

    // Loads the lane with fresh data, queues one handle and sets lane/gnt modes.
    task automatic prep(input vec_t v);
        handle_t h;
        for (int k = 0; k < 32; k++) lane_mem[k] = {8'($urandom()), 32'($urandom())};
        gmode       = v.gmode;
        lmode       = v.lmode;
        trickle_cnt = 0;
        lane_end    = 5'((int'(v.src) + int'(v.len)) % 32);
        if (v.lmode == L_FULL) lane_wptr = 5'((int'(v.src) + 31) % 32);
        else                   lane_wptr = v.src;
        h.drop      = v.drop;
        h.len       = v.len;
        h.page_addr = v.page;
        h.src_addr  = v.src;
        handle_mem[hptr_model] = h;
        got_q.delete();
        rd_q.delete();
        handle_wptr = hptr_model + 10'd1;
    endtask

    // Runs one handle to retirement and compares against the reference.
    task automatic run_handle(input vec_t v, input string tag);
        int         budget = 0;
        int         nexp;
        logic [9:0] exp_hptr;
        prep(v);
        exp_hptr = hptr_model + 10'd1;
        while (handle_rptr != exp_hptr && budget < BUDGET) begin
            tick();
            budget++;
        end
        chk({tag, "_timeout"}, 64'(budget >= BUDGET), 64'd0);
        hptr_model = exp_hptr;
        nexp = v.drop ? 0 : int'(v.len);
        chk({tag, "_n_writes"}, 64'(got_q.size()), 64'(v.exp_writes));
        chk({tag, "_n_reads"},  64'(rd_q.size()), 64'(nexp));
        for (int k = 0; k < nexp && k < got_q.size(); k++) begin
            chk($sformatf("%s_waddr%0d", tag, k), 64'(got_q[k].addr), 64'((int'(v.page) + k) % (1 << 18)));
            chk($sformatf("%s_wdata%0d", tag, k), 64'(got_q[k].data), 64'(lane_mem[(int'(v.src) + k) % 32]));
        end
        for (int k = 0; k < nexp && k < rd_q.size(); k++) begin
            chk($sformatf("%s_raddr%0d", tag, k), 64'(rd_q[k]), 64'((int'(v.src) + k) % 32));
        end
        if (v.exp_consec && nexp > 0 && got_q.size() == nexp) begin
            chk({tag, "_consecutive"}, 64'(got_q[nexp-1].cyc - got_q[0].cyc), 64'(nexp - 1));
        end
        chk({tag, "_lane_rptr"},   64'(lane_rptr), 64'(v.exp_lane_rptr));
        chk({tag, "_handle_rptr"}, 64'(handle_rptr), 64'(exp_hptr));
        chk({tag, "_idle_busy"},   64'(mover_busy), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   budget;

        //         drop  len    page       src    gnt       lane       rptr   wr  consec
        vecs[0] = '{1'b0, 8'd4,  18'h00100, 5'd3,  G_ONE,    L_FULL,    5'd7,  4,  1'b1};
        vecs[1] = '{1'b0, 8'd4,  18'h00200, 5'd30, G_ONE,    L_FULL,    5'd2,  4,  1'b1};
        vecs[2] = '{1'b0, 8'd2,  18'h3FFFF, 5'd10, G_ONE,    L_FULL,    5'd12, 2,  1'b1};
        vecs[3] = '{1'b1, 8'd5,  18'h00500, 5'd0,  G_ONE,    L_FULL,    5'd5,  0,  1'b0};
        vecs[4] = '{1'b0, 8'd8,  18'h01000, 5'd12, G_TOGGLE, L_TRICKLE, 5'd20, 8,  1'b0};
        vecs[5] = '{1'b0, 8'd0,  18'h00123, 5'd17, G_ONE,    L_FULL,    5'd17, 0,  1'b0};
        vecs[6] = '{1'b0, 8'd31, 18'h3FFF0, 5'd5,  G_RAND,   L_FULL,    5'd4,  31, 1'b0};
        vecs[7] = '{1'b0, 8'd6,  18'h00040, 5'd20, G_RAND,   L_TRICKLE, 5'd26, 6,  1'b0};

        rst         = 1'b1;
        handle_wptr = 10'd0;
        lane_wptr   = 5'd0;
        page_wr_gnt = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_handle(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset after two of six words have been granted.
        v = '{1'b0, 8'd6, 18'h02000, 5'd9, G_ONE, L_FULL, 5'd15, 6, 1'b0};
        prep(v);
        budget = 0;
        while (got_q.size() < 2 && budget < BUDGET) begin
            tick();
            budget++;
        end
        chk("midrst_timeout", 64'(budget >= BUDGET), 64'd0);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        handle_wptr = 10'd0;
        hptr_model  = 10'd0;
        @(negedge clk);
        #1;
        chk("midrst_abort_rd_en", 64'(lane_rd_en), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk_all_zero("midrst");
        tick();
        chk("midrst_not_retired", 64'(handle_rptr), 64'd0);
        chk("midrst_stays_idle",  64'(mover_busy), 64'd0);

        for (int i = 0; i < 20; i++) begin
            v.drop          = ($urandom_range(0, 7) == 0);
            v.len           = 8'($urandom_range(0, 31));
            v.page          = 18'($urandom());
            v.src           = 5'($urandom());
            v.gmode         = int'($urandom_range(0, 2));
            v.lmode         = int'($urandom_range(0, 1));
            v.exp_lane_rptr = 5'((int'(v.src) + int'(v.len)) % 32);
            v.exp_writes    = v.drop ? 0 : int'(v.len);
            v.exp_consec    = 1'b0;
            run_handle(v, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/block_mover.md
BLOCK_MOVER -- requirements
Module: block_mover

Interface
- REQ-001 SHALL have parameter LANE_FIFO_ADDR_W, default 5, meaning lane FIFO address width (depth 32).
- REQ-002 SHALL have parameter HANDLE_ADDR_W, default 10, meaning handle FIFO address width (depth 1024).
- REQ-003 SHALL have parameter PAGE_ADDR_W, default 18, meaning page RAM address width.
- REQ-004 SHALL have parameter MAX_PKT_LENGTH_BITS, default 8, meaning handle length field width.
- REQ-005 SHALL have parameter DATA_W, default 40, meaning lane and page word width.
- REQ-006 SHALL have port clk, input, 1 bit, the single clock.
- REQ-007 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
- REQ-008 SHALL have port handle_wptr, input, HANDLE_ADDR_W bits, handle FIFO write pointer.
- REQ-009 SHALL have port handle_rd_addr, output, HANDLE_ADDR_W bits, handle RAM read address (1-cycle read latency).
- REQ-010 SHALL have port handle_rd_data, input, HANDLE_W bits, handle RAM data; HANDLE_W = LANE_FIFO_ADDR_W+PAGE_ADDR_W+MAX_PKT_LENGTH_BITS+1 (32 at defaults).
- REQ-011 SHALL have port handle_rptr, output, HANDLE_ADDR_W bits, handles retired.
- REQ-012 SHALL have port lane_wptr, input, LANE_FIFO_ADDR_W bits, lane FIFO write pointer.
- REQ-013 SHALL have port lane_rd_en, output, 1 bit, lane RAM read strobe (data valid next cycle).
- REQ-014 SHALL have port lane_rd_addr, output, LANE_FIFO_ADDR_W bits, lane RAM read address.
- REQ-015 SHALL have port lane_rd_data, input, DATA_W bits, lane RAM read data.
- REQ-016 SHALL have port lane_rptr, output, LANE_FIFO_ADDR_W bits, lane words freed.
- REQ-017 SHALL have ports page_wr_req (output, 1 bit), page_wr_gnt (input, 1 bit), page_waddr (output, PAGE_ADDR_W bits), page_wdata (output, DATA_W bits); the page-write arbiter handshake.
- REQ-018 SHALL have port mover_busy, output, 1 bit, high while a handle is in flight.

Function
- REQ-019 Handle layout, MSB to LSB, SHALL be {drop(1), len(MAX_PKT_LENGTH_BITS), page_addr(PAGE_ADDR_W), src_addr(LANE_FIFO_ADDR_W)}; len counts words.
- REQ-020 FSM states SHALL be IDLE, FETCH, DECODE, MOVE, DONE.
- REQ-021 IDLE SHALL go to FETCH when handle_rptr != handle_wptr, and stay in IDLE otherwise.
- REQ-022 FETCH SHALL drive handle_rd_addr = handle_rptr for one cycle, then go to DECODE.
- REQ-023 DECODE SHALL latch the handle; drop=1 or len=0 goes to DONE without page writes; otherwise it goes to MOVE.
- REQ-024 MOVE SHALL assert lane_rd_en only when lane_rd_addr != lane_wptr (lane not empty) and the 2-entry output buffer has space; lane_rd_addr SHALL start at src_addr and increment mod 2^LANE_FIFO_ADDR_W.
- REQ-025 Word k SHALL be written to page_addr+k mod 2^PAGE_ADDR_W; page_wr_req/page_waddr/page_wdata SHALL hold stable until page_wr_gnt; a transfer occurs when req and gnt are both high.
- REQ-026 Throughput SHALL be 1 word/cycle with gnt held high and the lane non-empty; no word SHALL be lost or duplicated under any gnt pattern.
- REQ-027 MOVE SHALL go to DONE on the cycle the len-th word is granted.
- REQ-028 DONE SHALL, for one cycle, set lane_rptr = src_addr+len mod 2^LANE_FIFO_ADDR_W (this also applies to dropped handles) and handle_rptr += 1 mod 2^HANDLE_ADDR_W, then go to IDLE.
- REQ-029 mover_busy SHALL be high in FETCH, DECODE, MOVE and DONE, and low in IDLE.
- REQ-030 handle_rptr SHALL never pass handle_wptr, and lane reads SHALL never pass lane_wptr.

Reset
- REQ-031 On rst, the block SHALL enter IDLE; handle_rptr, lane_rptr, handle_rd_addr and lane_rd_addr SHALL be 0; lane_rd_en, page_wr_req and mover_busy SHALL be 0; the output buffer SHALL be emptied.
- REQ-032 rst mid-MOVE SHALL abort the handle within the same cycle, and the abandoned handle SHALL not be retired.

Configuration
- REQ-033 Macro BLOCK_MOVER_STATS_EN defined SHALL add outputs stat_words (32 bits, granted page writes) and stat_drops (16 bits, dropped handles); both saturate and reset to 0.
- REQ-034 Without BLOCK_MOVER_STATS_EN, those ports and counters SHALL be absent.

Structure
- REQ-035 A shared package SHALL hold the width parameters, HANDLE_W, the handle struct typedef and the FSM state enum.
- REQ-036 The block SHALL have one sub-module, bm_out_buf: a 2-entry skid buffer carrying {addr, data} to the page port.

Verification
- REQ-037 Bench SHALL cover: handle {0,4,0x100,3}, lane full, gnt=1 -> page writes 0x100..0x103 in 4 consecutive cycles from lane addrs 3..6; lane_rptr=7; handle_rptr=1.
- REQ-038 Bench SHALL cover: src_addr=30, len=4 -> lane reads 30,31,0,1; lane_rptr=2.
- REQ-039 Bench SHALL cover: page_addr=0x3FFFF, len=2 -> page writes 0x3FFFF then 0x00000.
- REQ-040 Bench SHALL cover: drop=1, len=5, src=0 -> no page_wr_req; lane_rptr=5; handle_rptr+1.
- REQ-041 Bench SHALL cover: gnt toggling 1010..., lane_wptr advancing 1 word every 3 cycles, len=8 -> exactly 8 in-order writes with no gaps in data.
- REQ-042 Bench SHALL cover: rst asserted after 2 of 6 words -> all outputs 0 next cycle; handle_rptr=0.
